// File: rtl/audio_pkg.sv
// audio_pkg: framing constants shared by the ADC capture and DAC playback paths.
package audio_pkg;
    localparam int FRAME_BITS = 8;
    localparam int BCLK_DIV_BIT = 2;
    localparam int LRCLK_BIT = 7;
    localparam int SAMPLE_BITS = 32;
    localparam int CHAN_BITS = 16;
    localparam logic [BCLK_DIV_BIT:0] SHIFT_PHASE = 3'b110;
endpackage

// File: rtl/audio_rx_fifo.sv
// audio_rx_fifo: show-ahead sample FIFO, extra pointer bit separates full from empty.
module audio_rx_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic                   clkrst_audio_clk,
    input  logic                   clkrst_audio_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [SAMPLE_BITS-1:0] push_data,
    output logic [SAMPLE_BITS-1:0] head,
    output logic                   full,
    output logic                   empty
);
    logic [SAMPLE_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr, rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                  (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    // Storage is not reset, so the head is masked to read zero while empty.
    assign head = empty ? '0 : mem[rd_ptr[ADDR_BITS-1:0]];

    always_ff @(posedge clkrst_audio_clk or posedge clkrst_audio_rst) begin
        if (clkrst_audio_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clkrst_audio_clk) begin
        if (push) mem[wr_ptr[ADDR_BITS-1:0]] <= push_data;
    end
endmodule

// File: rtl/audio_i2s_rx.sv
// audio_i2s_rx: ADC bit/word clock generation, serial capture of 32-bit stereo
// words and queueing toward the core-domain crossing buffer.
module audio_i2s_rx
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                   clkrst_audio_clk,
    input  logic                   clkrst_audio_rst,
    input  logic                   enable,
    input  logic                   clear_ovf,
    input  logic                   ext_adc_data,
    output logic                   ext_adc_bclk,
    output logic                   ext_adc_lrclk,
    output logic [SAMPLE_BITS-1:0] out_sample,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [7:0]             ovf_count
);
    logic [FRAME_BITS-1:0] ctr;
    logic [1:0] sync;
    logic [SAMPLE_BITS-1:0] sreg;
    logic armed, empty, full, pop, word_done, drop, push;

    assign ext_adc_bclk = ctr[BCLK_DIV_BIT];
    assign ext_adc_lrclk = ~ctr[LRCLK_BIT];
    assign out_valid = ~empty;
    assign pop = out_valid & out_ready;
    assign word_done = armed && (ctr == '1);
    // A full FIFO still accepts the word when the consumer frees a slot in the same cycle.
    assign drop = word_done & full & ~pop;
    assign push = word_done & ~drop;

    always_ff @(posedge clkrst_audio_clk or posedge clkrst_audio_rst) begin
        if (clkrst_audio_rst) begin
            ctr <= '0;
            sync <= '0;
            sreg <= '0;
            armed <= 1'b0;
            overflow <= 1'b0;
            ovf_count <= '0;
        end else begin
            ctr <= ctr + 1'b1;
            sync <= {sync[0], ext_adc_data};
            if (ctr[BCLK_DIV_BIT:0] == SHIFT_PHASE) sreg <= {sreg[SAMPLE_BITS-2:0], sync[1]};
            if (ctr == '0) armed <= enable;
            if (clear_ovf | drop) overflow <= drop;
            if (clear_ovf) ovf_count <= 8'(drop);
            else if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
        end
    end

    audio_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .ADDR_BITS(FIFO_ADDR_BITS)
    ) u_fifo (
        .clkrst_audio_clk(clkrst_audio_clk),
        .clkrst_audio_rst(clkrst_audio_rst),
        .push(push),
        .pop(pop),
        .push_data(sreg),
        .head(out_sample),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_audio_i2s_rx.sv
// tb_audio_i2s_rx: randomized ADC stream checked against a queue-based model of
// framing, arming, FIFO occupancy and overflow accounting.
module tb_audio_i2s_rx;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear_ovf = 1'b0, adc = 1'b0, ready = 1'b0;
    logic bclk, lrclk, out_valid, overflow;
    logic [31:0] out_sample;
    logic [7:0] ovf_count;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    audio_i2s_rx #(.FIFO_DEPTH(4), .FIFO_ADDR_BITS(2)) dut (
        .clkrst_audio_clk(clk),
        .clkrst_audio_rst(rst),
        .enable(enable),
        .clear_ovf(clear_ovf),
        .ext_adc_data(adc),
        .ext_adc_bclk(bclk),
        .ext_adc_lrclk(lrclk),
        .out_sample(out_sample),
        .out_valid(out_valid),
        .out_ready(ready),
        .overflow(overflow),
        .ovf_count(ovf_count)
    );

    int phase = 0;
    bit armed_m = 0, ovf_m = 0, fixed_mode = 0;
    int cnt_m = 0;
    logic [31:0] q[$];
    logic [31:0] tx_word = '0, fixed_word = 32'hA5A5_3C3C;

    // Reference: one word per 256-cycle frame, kept only if enable was high at frame start.
    always @(posedge clk or posedge rst) begin : model
        bit pop_m, push_m, drop_m;
        if (rst) begin
            phase = 0; armed_m = 0; ovf_m = 0; cnt_m = 0; q.delete();
        end else begin
            pop_m = q.size() > 0 && ready;
            push_m = phase == 255 && armed_m;
            drop_m = push_m && q.size() == 4 && !pop_m;
            if (phase == 0) armed_m = enable;
            if (pop_m) void'(q.pop_front());
            if (push_m && !drop_m) q.push_back(tx_word);
            if (drop_m) begin
                ovf_m = 1; cnt_m = clear_ovf ? 1 : (cnt_m < 255 ? cnt_m + 1 : 255);
            end else if (clear_ovf) begin
                ovf_m = 0; cnt_m = 0;
            end
            phase = (phase + 1) % 256;
        end
    end

    // ADC model: new bit on every bclk falling edge, MSB first, one word per frame.
    always @(negedge clk) begin
        if (phase % 8 == 0) begin
            if (phase == 0) tx_word = fixed_mode ? fixed_word : $urandom;
            adc = tx_word[31 - phase / 8];
        end
    end

    task automatic wait_phase(input int p);
        for (int i = 0; i < 260 && phase != p; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_sample !== 32'h0) begin errors++; $display("FAIL reset_sample got %h want 0", out_sample); end
        if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b want 0", bclk); end
        if (lrclk !== 1'b1) begin errors++; $display("FAIL reset_lrclk got %b want 1", lrclk); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (ovf_count !== 8'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", ovf_count); end
        rst = 1'b0;
    endtask

    task automatic test_clocks;
        logic prev_lr = lrclk, prev_b = bclk;
        int last_fall = -1, last_rise = -1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            checks += 2;
            if (bclk !== phase[2]) begin errors++; $display("FAIL clk_bclk k=%0d got %b want %b", k, bclk, phase[2]); end
            if (lrclk !== ~phase[7]) begin errors++; $display("FAIL clk_lrclk k=%0d got %b want %b", k, lrclk, ~phase[7]); end
            if (!prev_b && bclk) begin
                if (last_rise >= 0) begin
                    checks++;
                    if (k - last_rise != 8) begin errors++; $display("FAIL bclk_period got %0d want 8", k - last_rise); end
                end
                last_rise = k;
            end
            if (prev_lr && !lrclk) begin
                checks++;
                if (phase != 128) begin errors++; $display("FAIL lrclk_fall_pos got %0d want 128", phase); end
                if (last_fall >= 0) begin
                    checks++;
                    if (k - last_fall != 256) begin errors++; $display("FAIL lrclk_period got %0d want 256", k - last_fall); end
                end
                last_fall = k;
            end
            prev_lr = lrclk; prev_b = bclk;
        end
    endtask

    task automatic test_basic;
        int pulses = 0, first = -1;
        fixed_mode = 1; ready = 1;
        wait_phase(1);
        enable = 1;
        for (int k = 0; k < 768; k++) begin
            checks++;
            if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL basic_valid k=%0d got %b want %b", k, out_valid, q.size() != 0); end
            if (out_valid) begin
                pulses++;
                if (first < 0) first = k;
                checks++;
                if (out_sample !== 32'hA5A5_3C3C) begin errors++; $display("FAIL basic_sample got %h want a5a53c3c", out_sample); end
            end
            @(negedge clk);
        end
        checks += 2;
        if (pulses != 2) begin errors++; $display("FAIL basic_pulses got %0d want 2", pulses); end
        if (first != 511) begin errors++; $display("FAIL basic_first got %0d want 511", first); end
        fixed_mode = 0;
    endtask

    task automatic test_overflow;
        logic [31:0] exp[$];
        wait_phase(1);
        ready = 0;
        repeat (6 * 256) @(negedge clk);
        checks += 4;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        if (ovf_count !== 8'd2) begin errors++; $display("FAIL ovf_count got %0d want 2", ovf_count); end
        if (ovf_count !== 8'(cnt_m)) begin errors++; $display("FAIL ovf_model got %0d want %0d", ovf_count, cnt_m); end
        if (q.size() != 4) begin errors++; $display("FAIL ovf_depth model holds %0d want 4", q.size()); end
        clear_ovf = 1;
        @(negedge clk);
        clear_ovf = 0;
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_flag got %b want 0", overflow); end
        if (ovf_count !== 8'd0) begin errors++; $display("FAIL clr_count got %0d want 0", ovf_count); end
        exp = q;
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sample !== exp[i]) begin errors++; $display("FAIL ovf_order[%0d] got %b/%h want 1/%h", i, out_valid, out_sample, exp[i]); end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", out_valid); end
    endtask

    task automatic test_full_pop;
        logic [31:0] exp[$];
        logic [31:0] newest;
        wait_phase(1);
        ready = 0;
        repeat (4 * 256) @(negedge clk);
        wait_phase(255);
        newest = tx_word;
        ready = 1;
        @(negedge clk);
        ready = 0;
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        if (ovf_count !== 8'd0) begin errors++; $display("FAIL fullpop_cnt got %0d want 0", ovf_count); end
        exp = q;
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sample !== exp[i]) begin errors++; $display("FAIL fullpop_order[%0d] got %b/%h want 1/%h", i, out_valid, out_sample, exp[i]); end
            if (i == 3) begin
                checks++;
                if (out_sample !== newest) begin errors++; $display("FAIL fullpop_tail got %h want %h", out_sample, newest); end
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained got %b want 0", out_valid); end
    endtask

    task automatic test_enable;
        int pulses = 0, first = -1;
        ready = 1;
        wait_phase(8'h80);
        enable = 0;
        for (int k = 0; k < 768; k++) begin
            if (out_valid) begin
                pulses++; if (first < 0) first = k;
                checks++;
                if (q.size() == 0 || out_sample !== q[0]) begin errors++; $display("FAIL endrop_sample got %h", out_sample); end
            end
            @(negedge clk);
        end
        checks += 2;
        if (pulses != 1) begin errors++; $display("FAIL endrop_pulses got %0d want 1", pulses); end
        if (first != 128) begin errors++; $display("FAIL endrop_first got %0d want 128", first); end
        wait_phase(8'h40);
        enable = 1; pulses = 0; first = -1;
        for (int k = 0; k < 500; k++) begin
            if (out_valid) begin
                pulses++; if (first < 0) first = k;
                checks++;
                if (q.size() == 0 || out_sample !== q[0]) begin errors++; $display("FAIL reen_sample got %h", out_sample); end
            end
            @(negedge clk);
        end
        checks += 2;
        if (pulses != 1) begin errors++; $display("FAIL reen_pulses got %0d want 1", pulses); end
        if (first != 448) begin errors++; $display("FAIL reen_first got %0d want 448", first); end
    endtask

    task automatic test_reset_mid;
        int first = -1;
        wait_phase(1);
        ready = 0;
        repeat (2 * 256) @(negedge clk);
        wait_phase(8'h90);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", out_valid); end
        rst = 1;
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        if (out_sample !== 32'h0) begin errors++; $display("FAIL rstmid_sample got %h want 0", out_sample); end
        if (bclk !== 1'b0) begin errors++; $display("FAIL rstmid_bclk got %b want 0", bclk); end
        if (lrclk !== 1'b1) begin errors++; $display("FAIL rstmid_lrclk got %b want 1", lrclk); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b want 0", overflow); end
        if (ovf_count !== 8'h0) begin errors++; $display("FAIL rstmid_cnt got %h want 0", ovf_count); end
        repeat (3) @(negedge clk);
        rst = 0; ready = 1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (out_valid && first < 0) begin
                first = k;
                checks++;
                if (q.size() == 0 || out_sample !== q[0]) begin errors++; $display("FAIL rstmid_word got %h", out_sample); end
            end
        end
        checks++;
        if (first != 256) begin errors++; $display("FAIL rstmid_first got %0d want 256", first); end
    endtask

    initial begin
        test_reset;
        test_clocks;
        test_basic;
        test_overflow;
        test_full_pop;
        test_enable;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
